// File: rtl/clock_pkg.sv
// Shared widths, limits, FSM encoding and BCD helpers for the clock time keeper.
package clock_pkg;

    localparam int BCD_W   = 4;
    localparam int FIELD_W = 2 * BCD_W;

    localparam logic [FIELD_W-1:0] SEC_MAX = 8'h59;
    localparam logic [FIELD_W-1:0] MIN_MAX = 8'h59;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_CHECK = 1'b1
    } state_t;

    function automatic logic bcd_ok(input logic [FIELD_W-1:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic [FIELD_W-1:0] bcd_inc(input logic [FIELD_W-1:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [FIELD_W-1:0] bin_to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/bcd_mod60_counter.sv
// Two-digit BCD counter 00..MAX_VAL with synchronous load; carry flags the wrap back to 00.
module bcd_mod60_counter
    import clock_pkg::*;
#(
    parameter logic [FIELD_W-1:0] MAX_VAL = SEC_MAX
) (
    input  logic               clk_100,
    input  logic               rst,
    input  logic               i_inc,
    input  logic               i_load,
    input  logic [FIELD_W-1:0] i_load_val,
    output logic [FIELD_W-1:0] o_value,
    output logic               o_carry
);

    logic [FIELD_W-1:0] r_value;
    logic               w_at_max;

    assign w_at_max = (r_value == MAX_VAL);
    assign o_carry  = i_inc & w_at_max;
    assign o_value  = r_value;

    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            r_value <= '0;
        end else if (i_load) begin
            r_value <= i_load_val;
        end else if (i_inc) begin
            r_value <= w_at_max ? '0 : bcd_inc(r_value);
        end
    end

endmodule

// File: rtl/clock_time_keeper.sv
// Seconds time-base consumer: edge-detects sec_tog and keeps a BCD HH:MM:SS time of day.
// Define TWELVE_HOUR_EN for 12-hour mode with a PM flag; the default build is 24-hour.
module clock_time_keeper
    import clock_pkg::*;
#(
    parameter int HOUR_MAX = 23,
    parameter int RESET_HH = 0
) (
    input  logic               clk_100,
    input  logic               rst,
    input  logic               sec_tog,
    input  logic               run,
    input  logic               set_valid,
    output logic               set_ready,
    input  logic [FIELD_W-1:0] set_hh,
    input  logic [FIELD_W-1:0] set_mm,
    input  logic [FIELD_W-1:0] set_ss,
    input  logic               set_pm,
    output logic [FIELD_W-1:0] hh,
    output logic [FIELD_W-1:0] mm,
    output logic [FIELD_W-1:0] ss,
    output logic               pm,
    output logic               tick_sec,
    output logic               day_wrap,
    output logic               set_done,
    output logic               set_err,
    output logic               o_dbg_state
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_sec_tog_q;
    logic               r_tick_sec, r_day_wrap, r_set_done, r_set_err;
    logic [FIELD_W-1:0] r_hh, r_sh_hh, r_sh_mm, r_sh_ss;
    logic               w_rise, w_accept, w_load, w_reject, w_adv;
    logic               w_set_ok, w_hh_ok, w_ss_carry, w_mm_carry;

`ifdef TWELVE_HOUR_EN
    localparam logic [FIELD_W-1:0] HH_RESET = 8'h12;
    logic r_pm, r_sh_pm;
    assign w_hh_ok = (r_sh_hh >= 8'h01) && (r_sh_hh <= 8'h12);
    assign pm      = r_pm;
`else
    localparam logic [FIELD_W-1:0] HH_TOP   = bin_to_bcd(HOUR_MAX);
    localparam logic [FIELD_W-1:0] HH_RESET = bin_to_bcd(RESET_HH);
    logic w_unused_pm;
    assign w_unused_pm = set_pm;
    assign w_hh_ok     = (r_sh_hh <= HH_TOP);
    assign pm          = 1'b0;
`endif

    assign w_rise   = sec_tog & ~r_sec_tog_q;
    assign w_accept = set_valid & set_ready;
    assign w_set_ok = bcd_ok(r_sh_hh) && bcd_ok(r_sh_mm) && bcd_ok(r_sh_ss)
                   && (r_sh_mm <= MIN_MAX) && (r_sh_ss <= SEC_MAX) && w_hh_ok;
    // A valid load in the same cycle as a rise swallows that tick.
    assign w_adv    = w_rise & run & ~w_load;

    // set_valid/set_ready: a set transfers on a clk_100 edge where both are high;
    // set_ready then drops for the single validation cycle that follows.
    always_comb begin
        w_state_nxt = r_state;
        set_ready   = 1'b0;
        w_load      = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            S_RUN: begin
                set_ready = 1'b1;
                if (set_valid) w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                w_state_nxt = S_RUN;
                w_load      = w_set_ok;
                w_reject    = ~w_set_ok;
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_sec_tog_q <= 1'b0;
            r_tick_sec  <= 1'b0;
            r_set_done  <= 1'b0;
            r_set_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sec_tog_q <= sec_tog;
            r_tick_sec  <= w_adv;
            r_set_done  <= w_load;
            r_set_err   <= w_reject;
        end
    end

    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            r_sh_hh <= '0;
            r_sh_mm <= '0;
            r_sh_ss <= '0;
`ifdef TWELVE_HOUR_EN
            r_sh_pm <= 1'b0;
`endif
        end else if (w_accept) begin
            r_sh_hh <= set_hh;
            r_sh_mm <= set_mm;
            r_sh_ss <= set_ss;
`ifdef TWELVE_HOUR_EN
            r_sh_pm <= set_pm;
`endif
        end
    end

    bcd_mod60_counter #(.MAX_VAL(SEC_MAX)) u_ss (
        .clk_100    (clk_100),
        .rst        (rst),
        .i_inc      (w_adv),
        .i_load     (w_load),
        .i_load_val (r_sh_ss),
        .o_value    (ss),
        .o_carry    (w_ss_carry)
    );

    bcd_mod60_counter #(.MAX_VAL(MIN_MAX)) u_mm (
        .clk_100    (clk_100),
        .rst        (rst),
        .i_inc      (w_ss_carry),
        .i_load     (w_load),
        .i_load_val (r_sh_mm),
        .o_value    (mm),
        .o_carry    (w_mm_carry)
    );

    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            r_hh       <= HH_RESET;
            r_day_wrap <= 1'b0;
`ifdef TWELVE_HOUR_EN
            r_pm       <= 1'b0;
`endif
        end else begin
            r_day_wrap <= 1'b0;
            if (w_load) begin
                r_hh <= r_sh_hh;
`ifdef TWELVE_HOUR_EN
                r_pm <= r_sh_pm;
`endif
            end else if (w_mm_carry) begin
`ifdef TWELVE_HOUR_EN
                if (r_hh == 8'h12) begin
                    r_hh <= 8'h01;
                end else begin
                    r_hh <= bcd_inc(r_hh);
                    // 11 -> 12 flips AM/PM; leaving PM is the start of a new day.
                    if (r_hh == 8'h11) begin
                        r_pm       <= ~r_pm;
                        r_day_wrap <= r_pm;
                    end
                end
`else
                if (r_hh == HH_TOP) begin
                    r_hh       <= '0;
                    r_day_wrap <= 1'b1;
                end else begin
                    r_hh <= bcd_inc(r_hh);
                end
`endif
            end
        end
    end

    assign hh          = r_hh;
    assign tick_sec    = r_tick_sec;
    assign day_wrap    = r_day_wrap;
    assign set_done    = r_set_done;
    assign set_err     = r_set_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_clock_time_keeper.sv
// Self-checking bench for clock_time_keeper: directed scenarios plus random traffic,
// compared every cycle against a seconds-of-day reference model.
module tb_clock_time_keeper;

  localparam int HOUR_MAX = 23;
  localparam int RESET_HH = 7;
`ifdef TWELVE_HOUR_EN
  localparam int DAY     = 86400;
  localparam int RESET_T = 0;
`else
  localparam int DAY     = (HOUR_MAX + 1) * 3600;
  localparam int RESET_T = RESET_HH * 3600;
`endif

  logic       clk_100 = 1'b0;
  logic       rst = 1'b0;
  logic       sec_tog = 1'b0;
  logic       run = 1'b0;
  logic       set_valid = 1'b0;
  logic [7:0] set_hh = 8'h00;
  logic [7:0] set_mm = 8'h00;
  logic [7:0] set_ss = 8'h00;
  logic       set_pm = 1'b0;
  logic       set_ready;
  logic [7:0] hh, mm, ss;
  logic       pm, tick_sec, day_wrap, set_done, set_err, dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  // model state
  int          m_t = RESET_T;
  bit          m_tog_q = 1'b0;
  bit          m_check = 1'b0;
  bit          m_sh_ok = 1'b0;
  int          m_sh_t = 0;
  bit          e_tick = 1'b0, e_wrap = 1'b0, e_done = 1'b0, e_err = 1'b0;
  logic [31:0] exp_q[$];

  clock_time_keeper #(.HOUR_MAX(HOUR_MAX), .RESET_HH(RESET_HH)) dut (
    .clk_100     (clk_100),
    .rst         (rst),
    .sec_tog     (sec_tog),
    .run         (run),
    .set_valid   (set_valid),
    .set_ready   (set_ready),
    .set_hh      (set_hh),
    .set_mm      (set_mm),
    .set_ss      (set_ss),
    .set_pm      (set_pm),
    .hh          (hh),
    .mm          (mm),
    .ss          (ss),
    .pm          (pm),
    .tick_sec    (tick_sec),
    .day_wrap    (day_wrap),
    .set_done    (set_done),
    .set_err     (set_err),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk_100 = ~clk_100;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic int bcd_val(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  // {pm, hh, mm, ss} shown for a given second of the day
  function automatic logic [24:0] disp(input int t);
    int   h24, h;
    logic p;
    h24 = t / 3600;
`ifdef TWELVE_HOUR_EN
    h = (h24 % 12 == 0) ? 12 : h24 % 12;
    p = (h24 >= 12);
`else
    h = h24;
    p = 1'b0;
`endif
    return {p, to_bcd(h), to_bcd((t / 60) % 60), to_bcd(t % 60)};
  endfunction

  function automatic bit set_ok(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    int hv;
    if (h[7:4] > 9 || h[3:0] > 9 || m[7:4] > 9 || m[3:0] > 9 || s[7:4] > 9 || s[3:0] > 9)
      return 1'b0;
    if (bcd_val(m) > 59 || bcd_val(s) > 59) return 1'b0;
    hv = bcd_val(h);
`ifdef TWELVE_HOUR_EN
    return (hv >= 1) && (hv <= 12);
`else
    return hv <= HOUR_MAX;
`endif
  endfunction

  function automatic int set_t(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                               input logic p);
    int hv;
    hv = bcd_val(h);
`ifdef TWELVE_HOUR_EN
    hv = (hv % 12) + (p ? 12 : 0);
`else
    if (p) hv = hv;
`endif
    return hv * 3600 + bcd_val(m) * 60 + bcd_val(s);
  endfunction

  // reference model: one step per clk_100 edge
  always @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      m_t     <= RESET_T;
      m_tog_q <= 1'b0;
      m_check <= 1'b0;
      e_tick  <= 1'b0;
      e_wrap  <= 1'b0;
      e_done  <= 1'b0;
      e_err   <= 1'b0;
      exp_q.delete();
    end else begin
      e_done <= m_check && m_sh_ok;
      e_err  <= m_check && !m_sh_ok;
      e_tick <= 1'b0;
      e_wrap <= 1'b0;
      if (m_check && m_sh_ok) begin
        m_t <= m_sh_t;
      end else if (sec_tog && !m_tog_q && run) begin
        m_t    <= (m_t + 1) % DAY;
        e_tick <= 1'b1;
        e_wrap <= ((m_t + 1) % DAY) == 0;
        exp_q.push_back(32'((m_t + 1) % DAY));
      end
      if (!m_check && set_valid) begin
        m_check <= 1'b1;
        m_sh_ok <= set_ok(set_hh, set_mm, set_ss);
        m_sh_t  <= set_t(set_hh, set_mm, set_ss, set_pm);
      end else begin
        m_check <= 1'b0;
      end
      m_tog_q <= sec_tog;
    end
  end

  // scoreboard: every cycle, away from the active edge
  always @(negedge clk_100) begin
    if (chk_en) begin
      check_eq("time", {7'b0, pm, hh, mm, ss}, {7'b0, disp(m_t)});
      check_eq("tick_sec", {31'b0, tick_sec}, {31'b0, e_tick});
      check_eq("day_wrap", {31'b0, day_wrap}, {31'b0, e_wrap});
      check_eq("set_done", {31'b0, set_done}, {31'b0, e_done});
      check_eq("set_err", {31'b0, set_err}, {31'b0, e_err});
      check_eq("set_ready", {31'b0, set_ready}, {31'b0, !m_check});
      check_eq("one_hot_result", {31'b0, set_done & set_err}, 32'd0);
      if (tick_sec) begin
        if (exp_q.size() == 0) check_eq("tick_unexpected", {31'b0, tick_sec}, 32'd0);
        else check_eq("tick_time", {7'b0, pm, hh, mm, ss}, {7'b0, disp(int'(exp_q.pop_front()))});
      end
    end
  end

  // driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_100);
  endtask

  task automatic pulse_sec(input int hi, input int lo);
    sec_tog = 1'b1;
    wait_cyc(hi);
    sec_tog = 1'b0;
    wait_cyc(lo);
  endtask

  task automatic send_set(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                          input logic p);
    set_hh = h;
    set_mm = m;
    set_ss = s;
    set_pm = p;
    set_valid = 1'b1;
    wait_cyc(1);
    set_valid = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    check_eq("rst_time", {7'b0, pm, hh, mm, ss}, {7'b0, disp(RESET_T)});
    check_eq("rst_ready", {31'b0, set_ready}, 32'd1);

    // three seconds
    run = 1'b1;
    for (int i = 0; i < 3; i++) pulse_sec(3, 4);
    check_eq("ss_after_3", {24'b0, ss}, 32'h03);

    // rollover to start of day
`ifdef TWELVE_HOUR_EN
    send_set(8'h11, 8'h59, 8'h59, 1'b1);
    wait_cyc(2);
    pulse_sec(2, 3);
    check_eq("noon_midnight_wrap", {7'b0, pm, hh, mm, ss}, {7'b0, 1'b0, 24'h120000});
`else
    send_set(8'h23, 8'h59, 8'h58, 1'b0);
    wait_cyc(2);
    pulse_sec(2, 3);
    check_eq("pre_wrap", {8'b0, hh, mm, ss}, 32'h235959);
    pulse_sec(2, 3);
    check_eq("day_wrap_time", {8'b0, hh, mm, ss}, 32'h000000);
`endif

    // rejected sets leave time alone
    send_set(8'h24, 8'h00, 8'h00, 1'b0);
    wait_cyc(3);
    send_set(8'h12, 8'h5A, 8'h00, 1'b0);
    wait_cyc(3);

    // paused time ignores rises
    run = 1'b0;
    for (int i = 0; i < 5; i++) pulse_sec(2, 2);
    run = 1'b1;
    pulse_sec(2, 2);
    check_eq("run_resume_ss", {24'b0, ss}, 32'h01);

    // rise landing in the validation cycle
    send_set(8'h10, 8'h20, 8'h30, 1'b0);
    pulse_sec(3, 3);
    check_eq("valid_set_beats_rise", {8'b0, hh, mm, ss}, 32'h102030);
    send_set(8'h10, 8'h1A, 8'h00, 1'b0);
    pulse_sec(3, 3);
    check_eq("invalid_set_rise_adv", {8'b0, hh, mm, ss}, 32'h102031);

    // rise in the accept cycle
    sec_tog = 1'b1;
    send_set(8'h05, 8'h06, 8'h07, 1'b0);
    wait_cyc(2);
    sec_tog = 1'b0;
    wait_cyc(2);
    check_eq("rise_at_accept", {8'b0, hh, mm, ss}, 32'h050607);

    // asynchronous reset while validating
    set_hh = 8'h09; set_mm = 8'h09; set_ss = 8'h09; set_pm = 1'b0;
    set_valid = 1'b1;
    @(posedge clk_100);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_time", {7'b0, pm, hh, mm, ss}, {7'b0, disp(RESET_T)});
    check_eq("async_rst_ready", {31'b0, set_ready}, 32'd1);
    check_eq("async_rst_done", {31'b0, set_done}, 32'd0);
    @(negedge clk_100);
    set_valid = 1'b0;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(3);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) sec_tog = ~sec_tog;
      run = ($urandom_range(0, 9) != 0);
      set_valid = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 0) begin
`ifdef TWELVE_HOUR_EN
        set_hh = to_bcd($urandom_range(1, 12));
`else
        set_hh = to_bcd($urandom_range(0, HOUR_MAX));
`endif
        set_mm = ($urandom_range(0, 1) == 0) ? 8'h59 : to_bcd($urandom_range(0, 59));
        set_ss = ($urandom_range(0, 2) != 0) ? to_bcd($urandom_range(55, 59))
                                             : to_bcd($urandom_range(0, 59));
      end else begin
        set_hh = 8'($urandom_range(0, 255));
        set_mm = 8'($urandom_range(0, 255));
        set_ss = 8'($urandom_range(0, 255));
      end
      set_pm = 1'($urandom_range(0, 1));
      wait_cyc(1);
    end

    set_valid = 1'b0;
    sec_tog = 1'b0;
    wait_cyc(5);
    check_eq("tick_q_left", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clock_time_keeper.md
Name: clock_time_keeper

Overview:
- Consumer end of the seconds time-base for the digital clock.
- Takes the 1 Hz square wave `sec_tog` produced by the one-second generator, which toggles every 50,000,000 cycles of `clk_100`.
- Detects its rising edge and advances a BCD HH:MM:SS time-of-day register.
- Accepts a validated set-time load over a valid/ready handshake; feeds the display/7-seg driver.

Parameters:
- HOUR_MAX, 23, highest hour value in 24-hour mode (ignored when TWELVE_HOUR_EN is defined).
- RESET_HH, 0, hour loaded at reset (24-hour mode, binary 0..23, converted to BCD internally).

Ports:
- clk_100  in  1  100 MHz system clock
- rst  in  1  asynchronous, active-high reset
- sec_tog  in  1  1 Hz square wave from the seconds generator, synchronous to clk_100
- run  in  1  1 = time advances on seconds ticks; 0 = paused (ticks ignored)
- set_valid  in  1  set request
- set_ready  out  1  block can accept a set request
- set_hh  in  8  BCD hours {tens,ones}
- set_mm  in  8  BCD minutes
- set_ss  in  8  BCD seconds
- set_pm  in  1  PM flag for the set (used only with TWELVE_HOUR_EN)
- hh  out  8  BCD hours
- mm  out  8  BCD minutes
- ss  out  8  BCD seconds
- pm  out  1  PM indicator (constant 0 without TWELVE_HOUR_EN)
- tick_sec  out  1  one-cycle pulse, same cycle the time outputs show an advanced value
- day_wrap  out  1  one-cycle pulse when time wraps to the start of day
- set_done  out  1  one-cycle pulse: set value accepted and loaded
- set_err  out  1  one-cycle pulse: set value rejected

Behaviour:
- Reset (async): hh = RESET_HH (BCD), mm = 00, ss = 00, pm = 0, sec_tog_q = 0, all pulse outputs 0, set_ready = 1, FSM = S_RUN.
- Edge detect:
  - `rise = sec_tog & ~sec_tog_q`; `sec_tog_q` is registered every cycle.
  - Time registers update on the same clk_100 edge that captures `sec_tog_q = 1`, i.e. 1 cycle after `sec_tog` rises.
  - Falling edges are ignored.
- Advance (rise & run, FSM in S_RUN):
  - ss increments in BCD: ones 9→0 carries to tens; 59→00 carries to mm.
  - mm increments the same way; 59→00 carries to hh.
  - hh: 09→10; HOUR_MAX→00 with day_wrap = 1.
  - tick_sec = 1 for that cycle.
- run = 0: rise is consumed; no advance and no tick_sec.
- FSM states S_RUN and S_CHECK:
  - S_RUN: set_ready = 1. If set_valid & set_ready, capture set_* into shadow registers and go to S_CHECK.
  - S_CHECK: set_ready = 0. Validate the shadow value; always return to S_RUN next cycle.
  - Valid value: load hh/mm/ss/pm, set_done = 1.
  - Invalid value: time unchanged, set_err = 1.
- Validation rules:
  - Every nibble ≤ 9.
  - ss ≤ 59, mm ≤ 59.
  - 24-hour mode: hh ≤ HOUR_MAX.
  - 12-hour mode: 01 ≤ hh ≤ 12.
- Simultaneous events:
  - rise in the cycle a set is accepted: advance is applied normally.
  - rise during S_CHECK with a valid set: load wins, tick is dropped (tick_sec = 0).
  - rise during S_CHECK with an invalid set: advance is applied, tick_sec = 1 alongside set_err.
- Reset mid-S_CHECK: abort to the reset state; the shadow value is discarded.
- At most one of set_done and set_err is asserted per cycle.

Optional Feature:
- Macro: TWELVE_HOUR_EN.
- Defined:
  - hh range is 01..12.
  - Reset value 12:00:00 with pm = 0.
  - Advance 11:59:59→12:00:00 toggles pm.
  - 12:59:59→01:00:00 leaves pm unchanged.
  - day_wrap fires on the PM→AM transition (11:59:59 PM → 12:00:00 AM).
  - set_pm is loaded into pm.
- Undefined: 24-hour behaviour as above; pm tied 0; set_pm ignored.

Decomposition:
- Package `clock_pkg`:
  - BCD digit width (4) and field width (8).
  - Constants SEC_MAX = 8'h59, MIN_MAX = 8'h59.
  - FSM state encodings S_RUN / S_CHECK.
  - BCD-validity function.
- Sub-module `bcd_mod60_counter`:
  - Two-digit BCD with inc, load, load_val; outputs value and carry.
  - Instantiated for ss and mm.
- Hours and PM logic stay in the top level.

Test Plan:
- Reset, then 3 sec_tog rising edges with run = 1 → ss = 03; tick_sec pulses 3 times, each 1 cycle after the rise; falling edges produce nothing.
- Set 23:59:58 (valid, set_done), then 2 rises → 23:59:59, then 00:00:00 with day_wrap = 1 on the second; with TWELVE_HOUR_EN, set 11:59:59 pm = 1 → 12:00:00 pm = 0, day_wrap = 1.
- Set hh = 8'h24, then separately mm = 8'h5A → set_err = 1 each time; time unchanged; set_ready low exactly 1 cycle after each accept.
- run = 0 with 5 rises → time frozen, no tick_sec; run = 1 then 1 rise → ss advances by exactly 1.
- Valid set accepted with a rise landing in S_CHECK → loaded value appears unmodified, tick_sec = 0; repeat with an invalid set → time advances by 1, set_err = 1.
- Assert rst during S_CHECK → outputs return to reset values immediately (async), set_ready = 1, no set_done.
